// File: rtl/seg_595_pkg.sv
// seg_595_pkg: shared widths, seven-segment hex table and reverse-lookup helper
// for the 74HC595 link receiver.
`default_nettype none

package seg_595_pkg;

   localparam int SEL_W_DEF   = 6;
   localparam int SEG_W_DEF   = 8;
   localparam int FRAME_W_DEF = SEL_W_DEF + SEG_W_DEF;
   localparam int DP_BIT      = 7;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Common-anode, active-low codes for 0..F with the decimal point off
   localparam logic [7:0] SEG_HEX [0:15] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   typedef struct packed {
      logic       ok;
      logic [3:0] val;
   } hex_dec_t;

   function automatic hex_dec_t seg_lookup(input logic [7:0] code);
      hex_dec_t   r;
      logic [7:0] m;
      r         = '0;
      m         = code;
      m[DP_BIT] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (m == SEG_HEX[i]) begin
            r.ok  = 1'b1;
            r.val = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg_595_receiver_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for one asynchronous input followed by
// an edge register producing a single-cycle rising-edge strobe.
`default_nettype none

module sync_edge_det #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_lvl,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_lvl  = r_sync[SYNC_STAGES-1];
   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/seg_595_receiver.sv
// seg_595_receiver: deserialises 74HC595 seven-segment frames into a 6-digit display image.
// Optional macro SEG_DECODE_EN adds a registered per-digit hex reverse lookup.
`default_nettype none

module seg_595_receiver
   import seg_595_pkg::*;
#(
   parameter int SEL_W       = SEL_W_DEF,
   parameter int SEG_W       = SEG_W_DEF,
   parameter int FRAME_W     = FRAME_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   shcp,
   input  logic                   stcp,
   input  logic                   ds,
   input  logic                   oe,
   output logic                   frame_vld,
   output logic [2:0]             digit_idx,
   output logic [SEG_W-1:0]       seg_code,
   output logic [SEL_W*SEG_W-1:0] disp_buf,
   output logic                   blank,
   output logic                   frame_err,
   output logic                   sel_err,
   output logic [4*SEL_W-1:0]     hex_val,
   output logic [SEL_W-1:0]       hex_ok
);

   logic w_shcp_rise, w_stcp_rise, w_ds, w_ds_rise, w_oe_rise;
   logic w_shcp_lvl, w_stcp_lvl, w_unused;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_shcp (
      .clk(sys_clk), .rst(sys_rst), .i_d(shcp), .o_lvl(w_shcp_lvl), .o_rise(w_shcp_rise));
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_stcp (
      .clk(sys_clk), .rst(sys_rst), .i_d(stcp), .o_lvl(w_stcp_lvl), .o_rise(w_stcp_rise));
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ds (
      .clk(sys_clk), .rst(sys_rst), .i_d(ds), .o_lvl(w_ds), .o_rise(w_ds_rise));
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_oe (
      .clk(sys_clk), .rst(sys_rst), .i_d(oe), .o_lvl(blank), .o_rise(w_oe_rise));

   assign w_unused = w_ds_rise ^ w_oe_rise ^ w_shcp_lvl ^ w_stcp_lvl;

   logic [FRAME_W-1:0]     r_sr;
   logic [3:0]             r_bit_cnt;
   logic                   r_vld, r_ferr, r_serr;
   logic [2:0]             r_idx;
   logic [SEG_W-1:0]       r_seg_code;
   logic [SEL_W*SEG_W-1:0] r_disp;

   logic [SEL_W-1:0] w_sel;
   logic [SEG_W-1:0] w_seg;
   logic [3:0]       w_nz;
   logic [2:0]       w_idx;

   // First bit on the wire is sel[0], so select is bit-reversed at the top of sr
   always_comb begin
      w_nz  = '0;
      w_idx = '0;
      for (int i = 0; i < SEL_W; i++) begin
         w_sel[i] = r_sr[FRAME_W-1-i];
         if (!w_sel[i]) begin
            w_nz  = w_nz + 4'd1;
            w_idx = 3'(i);
         end
      end
      w_seg = r_sr[SEG_W-1:0];
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_vld      <= 1'b0;
         r_ferr     <= 1'b0;
         r_serr     <= 1'b0;
         r_idx      <= '0;
         r_seg_code <= {SEG_W{1'b1}};
         r_disp     <= {SEL_W*SEG_W{1'b1}};
      end else begin
         r_vld <= 1'b0;
         // Latch reads the pre-shift register, mirroring the 595 storage stage lag
         if (w_stcp_rise) begin
            r_vld      <= 1'b1;
            r_seg_code <= w_seg;
            if (r_bit_cnt != 4'(FRAME_W))
               r_ferr <= 1'b1;
            if (w_nz != 4'd1) begin
               r_serr <= 1'b1;
            end else if (r_bit_cnt != 4'd0) begin
               r_idx <= w_idx;
               for (int n = 0; n < SEL_W; n++) begin
                  if (w_idx == 3'(n))
                     r_disp[n*SEG_W +: SEG_W] <= w_seg;
               end
            end
            r_bit_cnt <= w_shcp_rise ? 4'd1 : 4'd0;
         end else if (w_shcp_rise && r_bit_cnt != 4'hF) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
         if (w_shcp_rise)
            r_sr <= {r_sr[FRAME_W-2:0], w_ds};
      end
   end

   assign frame_vld = r_vld;
   assign digit_idx = r_idx;
   assign seg_code  = r_seg_code;
   assign disp_buf  = r_disp;
   assign frame_err = r_ferr;
   assign sel_err   = r_serr;

`ifdef SEG_DECODE_EN
   generate
      for (genvar n = 0; n < SEL_W; n++) begin : g_dec
         hex_dec_t   w_dec;
         logic [3:0] r_val;
         logic       r_ok;

         assign w_dec = seg_lookup(r_disp[n*SEG_W +: 8]);

         always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
               r_val <= '0;
               r_ok  <= 1'b0;
            end else begin
               r_val <= w_dec.ok ? w_dec.val : 4'd0;
               r_ok  <= w_dec.ok;
            end
         end

         assign hex_val[4*n +: 4] = r_val;
         assign hex_ok[n]         = r_ok;
      end
   endgenerate
`else
   assign hex_val = '0;
   assign hex_ok  = '0;
`endif

endmodule

`default_nettype wire
